// File: rtl/data_mem_port.sv
// ---------------------------------------------------------------------------
// data_mem_port
//   Bridges the load/store control stage to a word-wide synchronous data SRAM.
//   Converts a byte-addressed load/store of 1, 2 or 4 bytes into SRAM word
//   accesses with byte enables and lane-shifted write data, and returns
//   right-justified, zero-extended load data.
//
//   Optional feature macro: MEM_SPLIT_EN
//     defined   : word-crossing requests run as two SRAM beats (w, w+1)
//     undefined : word-crossing requests are rejected with err
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   load, store         request strobes (sampled only while idle)
//   xfer_size[2:0]      byte count: 1, 2 or 4
//   addr[31:0]          byte address
//   wr_data[31:0]       right-justified store data
//   busy                high whenever an access is in flight
//   rd_valid            one-cycle pulse, rd_data valid
//   rd_data[31:0]       right-justified, zero-extended load data
//   err                 one-cycle pulse, request rejected
//   mem_en, mem_we      SRAM strobe / write enable
//   mem_addr[ADDR_W-1:0] SRAM word address
//   mem_be[3:0]         byte enables, bit i = lane i
//   mem_wdata[31:0]     lane-aligned write data
//   mem_rdata[31:0]     SRAM read data, valid the cycle after a read strobe
// ---------------------------------------------------------------------------
module data_mem_port #(
    parameter int unsigned ADDR_W = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              store,
    input  logic [2:0]        xfer_size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wr_data,
    output logic              busy,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE0, ISSUE1, CAPT} state_e;

    state_e state_q, state_d;

    // Latched request
    logic [ADDR_W-1:0] word_q;
    logic [1:0]        off_q;
    logic [2:0]        size_q;
    logic [31:0]       wdata_q;
    logic              is_load_q;
`ifdef MEM_SPLIT_EN
    logic              cross_q;
    logic [31:0]       beat0_q;
`endif

    // Output registers
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        err_q, err_d;

    // ---------------- request decode ----------------
    logic       req, one_dir, size_ok, crosses, legal, accept, reject;
    logic [3:0] end_byte;

    assign req      = load | store;
    assign one_dir  = load ^ store;
    assign size_ok  = (xfer_size == 3'd1) || (xfer_size == 3'd2) || (xfer_size == 3'd4);
    assign end_byte = {2'b00, addr[1:0]} + {1'b0, xfer_size};
    assign crosses  = end_byte > 4'd4;
`ifdef MEM_SPLIT_EN
    assign legal    = one_dir && size_ok;
`else
    assign legal    = one_dir && size_ok && !crosses;
`endif
    assign accept   = (state_q == IDLE) && legal;
    assign reject   = (state_q == IDLE) && req && !legal;

    // ---------------- lane math on latched request ----------------
    logic [3:0]  mask4;
    logic [31:0] byte_mask;

    always_comb begin
        case (size_q)
            3'd1:    mask4 = 4'b0001;
            3'd2:    mask4 = 4'b0011;
            default: mask4 = 4'b1111;
        endcase
    end

    assign byte_mask = {{8{mask4[3]}}, {8{mask4[2]}}, {8{mask4[1]}}, {8{mask4[0]}}};

`ifdef MEM_SPLIT_EN
    // Upper halves feed the second beat of a crossing access.
    logic [7:0]  be_all;
    logic [63:0] lanes;
    logic [63:0] rd_pair;
    logic [31:0] rd_window;
    assign be_all    = {4'b0000, mask4} << off_q;
    assign lanes     = {32'h0, wdata_q} << {off_q, 3'b000};
    assign rd_pair   = cross_q ? {mem_rdata, beat0_q} : {32'h0, mem_rdata};
    assign rd_window = rd_pair[{off_q, 3'b000} +: 32];
`else
    logic [3:0]  be_all;
    logic [31:0] lanes;
    logic [31:0] rd_window;
    assign be_all    = mask4 << off_q;
    assign lanes     = wdata_q << {off_q, 3'b000};
    assign rd_window = mem_rdata >> {off_q, 3'b000};
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (accept) state_d = ISSUE0;
            ISSUE0: begin
`ifdef MEM_SPLIT_EN
                if (cross_q)        state_d = ISSUE1;
                else
`endif
                if (is_load_q)      state_d = CAPT;
                else                state_d = IDLE;
            end
`ifdef MEM_SPLIT_EN
            ISSUE1: state_d = is_load_q ? CAPT : IDLE;
`endif
            CAPT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        err_d      = reject;
        case (state_q)
            ISSUE0: begin
                mem_en    = 1'b1;
                mem_we    = !is_load_q;
                mem_addr  = word_q;
                mem_be    = be_all[3:0];
                mem_wdata = is_load_q ? '0 : lanes[31:0];
            end
`ifdef MEM_SPLIT_EN
            ISSUE1: begin
                mem_en    = 1'b1;
                mem_we    = !is_load_q;
                mem_addr  = word_q + ADDR_W'(1);
                mem_be    = be_all[7:4];
                mem_wdata = is_load_q ? '0 : lanes[63:32];
            end
`endif
            CAPT: begin
                rd_valid_d = 1'b1;
                rd_data_d  = rd_window & byte_mask;
            end
            default: ;
        endcase
    end

    // ---------------- request capture and output registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q     <= '0;
            off_q      <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            is_load_q  <= 1'b0;
`ifdef MEM_SPLIT_EN
            cross_q    <= 1'b0;
            beat0_q    <= '0;
`endif
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                word_q    <= addr[ADDR_W+1:2];
                off_q     <= addr[1:0];
                size_q    <= xfer_size;
                wdata_q   <= wr_data;
                is_load_q <= load;
`ifdef MEM_SPLIT_EN
                cross_q   <= crosses;
`endif
            end
`ifdef MEM_SPLIT_EN
            // Beat0 read data arrives while the second beat is being issued.
            if (state_q == ISSUE1) beat0_q <= mem_rdata;
`endif
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_data_mem_port.sv
module tb_data_mem_port;

    localparam int unsigned ADDR_W = 30;

    logic              clk = 1'b0;
    logic              reset;
    logic              load, store;
    logic [2:0]        xfer_size;
    logic [31:0]       addr, wr_data;
    logic              busy, rd_valid, err;
    logic [31:0]       rd_data;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    // Small SRAM model (64 words, aliased on low address bits)
    logic [31:0] mem [0:63];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_a;
    logic [31:0] poke_d;

    always #5 clk = ~clk;

    data_mem_port #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .load(load), .store(store),
        .xfer_size(xfer_size), .addr(addr), .wr_data(wr_data),
        .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (poke_en) mem[poke_a] <= poke_d;
        else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[5:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [5:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_a = a; poke_d = d;
        cyc();
        poke_en = 1'b0;
    endtask

    // Drive a request during cycle T; returns positioned in cycle T+1.
    task automatic issue(input logic ld, input logic st, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        load = ld; store = st; xfer_size = sz; addr = a; wr_data = wd;
        cyc();
        load = 1'b0; store = 1'b0; xfer_size = 3'd0; addr = '0; wr_data = '0;
    endtask

    initial begin
        logic seen;
        reset = 1'b1; load = 1'b0; store = 1'b0; xfer_size = '0; addr = '0; wr_data = '0;
        mem_rdata = '0;
        cyc(); cyc();
        chk("rst_busy", busy, 0);
        chk("rst_rdv", rd_valid, 0);
        chk("rst_rdata", rd_data, 0);
        chk("rst_err", err, 0);
        chk("rst_mem", {mem_en, mem_we, mem_be, mem_addr}, 0);
        chk("rst_wdata", mem_wdata, 0);
        reset = 1'b0;
        cyc();

        // 1. SW 0x10
        issue(0, 1, 3'd4, 32'h10, 32'hDEADBEEF);
        chk("sw_en_we", {mem_en, mem_we}, 2'b11);
        chk("sw_addr", mem_addr, 4);
        chk("sw_be", mem_be, 4'b1111);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_busy", busy, 1);
        cyc();
        chk("sw_done", {busy, mem_en}, 0);

        // 2. SB 0x13
        issue(0, 1, 3'd1, 32'h13, 32'h000000A5);
        chk("sb_addr", mem_addr, 4);
        chk("sb_be", mem_be, 4'b1000);
        chk("sb_wdata", mem_wdata, 32'hA5000000);
        cyc();

        // Read back word 4 after both stores
        issue(1, 0, 3'd4, 32'h10, 32'h0);
        chk("lw_we", {mem_en, mem_we}, 2'b10);
        cyc(); cyc();
        chk("lw_rdv", rd_valid, 1);
        chk("lw_rdata", rd_data, 32'hA5ADBEEF);

        // 3. LH 0x22
        poke(6'd8, 32'h12345678);
        issue(1, 0, 3'd2, 32'h22, 32'h0);
        chk("lh_addr", mem_addr, 8);
        chk("lh_be", mem_be, 4'b1100);
        cyc();
        chk("lh_capt", {busy, mem_en, rd_valid}, 3'b100);
        cyc();
        chk("lh_rdv", {rd_valid, busy}, 2'b10);
        chk("lh_rdata", rd_data, 32'h00001234);
        // New request in the rd_valid cycle
        issue(1, 0, 3'd1, 32'h20, 32'h0);
        chk("b2b_rdv_drop", rd_valid, 0);
        chk("b2b_rdata_hold", rd_data, 32'h00001234);
        chk("b2b_issue", {mem_en, mem_be}, {1'b1, 4'b0001});
        cyc(); cyc();
        chk("lb20_rdata", {rd_valid, rd_data}, {1'b1, 32'h00000078});
        issue(1, 0, 3'd1, 32'h23, 32'h0);
        cyc(); cyc();
        chk("lb23_rdata", {rd_valid, rd_data}, {1'b1, 32'h00000012});

        // 4. LW 0x0E (crossing)
        poke(6'd3, 32'hAABBCCDD);
        poke(6'd4, 32'h11223344);
        issue(1, 0, 3'd4, 32'h0E, 32'h0);
`ifdef MEM_SPLIT_EN
        chk("lwx_b0", {mem_en, mem_we, mem_be, mem_addr}, {2'b10, 4'b1100, 30'd3});
        cyc();
        chk("lwx_b1", {mem_en, mem_we, mem_be, mem_addr}, {2'b10, 4'b0011, 30'd4});
        cyc();
        chk("lwx_capt", {busy, mem_en, rd_valid}, 3'b100);
        cyc();
        chk("lwx_rdata", {rd_valid, rd_data}, {1'b1, 32'h3344AABB});
`else
        chk("lwx_err", {err, mem_en, busy}, 3'b100);
        cyc();
        chk("lwx_err_pulse", err, 0);
`endif

        // 5. SH 0x0F (crossing)
        issue(0, 1, 3'd2, 32'h0F, 32'h0000BEEF);
`ifdef MEM_SPLIT_EN
        chk("shx_b0", {mem_en, mem_we, mem_be, mem_addr}, {2'b11, 4'b1000, 30'd3});
        chk("shx_b0_wd", mem_wdata, 32'hEF000000);
        cyc();
        chk("shx_b1", {mem_en, mem_we, mem_be, mem_addr}, {2'b11, 4'b0001, 30'd4});
        chk("shx_b1_wd", mem_wdata, 32'h000000BE);
        cyc();
        chk("shx_done", busy, 0);
        // Word address wrap on the second beat
        issue(0, 1, 3'd2, 32'hFFFFFFFF, 32'h00001234);
        chk("wrap_b0", {mem_be, mem_addr, mem_wdata}, {4'b1000, 30'h3FFFFFFF, 32'h34000000});
        cyc();
        chk("wrap_b1", {mem_be, mem_addr, mem_wdata}, {4'b0001, 30'd0, 32'h00000012});
        cyc();
`else
        chk("shx_err", {err, mem_en, busy}, 3'b100);
        cyc();
`endif

        // 6. Reset during an in-flight load
`ifdef MEM_SPLIT_EN
        issue(1, 0, 3'd4, 32'h0E, 32'h0);
        cyc();
        chk("abort_in_issue1", {mem_en, mem_addr}, {1'b1, 30'd4});
`else
        issue(1, 0, 3'd4, 32'h10, 32'h0);
        chk("abort_in_issue0", mem_en, 1);
`endif
        reset = 1'b1;
        cyc();
        chk("abort_idle", {busy, mem_en, rd_valid}, 3'b000);
        chk("abort_rdata_clr", rd_data, 0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            cyc();
            if (rd_valid || err) seen = 1'b1;
        end
        chk("abort_no_pulse", seen, 0);

        // load and store together
        issue(1, 1, 3'd4, 32'h10, 32'h0);
        chk("ldst_err", {err, mem_en, busy}, 3'b100);
        cyc();
        chk("ldst_err_pulse", {err, mem_en}, 2'b00);

        // illegal size
        issue(1, 0, 3'd3, 32'h10, 32'h0);
        chk("size3_err", {err, mem_en, busy}, 3'b100);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_port.md
Name: data_mem_port

Overview:
- Sits between the load/store control stage and the word-wide synchronous data SRAM.
- Accepts a load or store with a byte address, a transfer size and right-justified write data.
- Generates word address, byte enables and lane-shifted write data, and returns right-justified, zero-extended read data; the upstream stage applies sign extension.
- Misaligned accesses that cross a word boundary are split into two SRAM beats when the optional feature is compiled in.

Parameters:
ADDR_W, 30, SRAM word-address width; mem_addr = addr[ADDR_W+1:2].

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
load  in  1  load request (sampled only in IDLE)
store  in  1  store request (sampled only in IDLE)
xfer_size  in  3  bytes to transfer: 1, 2 or 4
addr  in  32  byte address
wr_data  in  32  store data, right-justified
busy  out  1  stall upstream; high whenever state != IDLE
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_data  out  32  load data, right-justified, zero above xfer_size bytes
err  out  1  one-cycle pulse, request rejected
mem_en  out  1  SRAM access strobe
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_W  SRAM word address
mem_be  out  4  byte enables, bit i = byte lane i
mem_wdata  out  32  lane-aligned write data
mem_rdata  in  32  SRAM read data, valid the cycle after a read strobe

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. Reset forces state IDLE and clears all output registers and capture registers. Reset values: busy=0, rd_valid=0, rd_data=0, err=0, mem_en=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- FSM states: IDLE, ISSUE0, ISSUE1, CAPT.
- mem_* outputs decode combinationally from state and latched request; all mem_* are 0 in IDLE and CAPT-without-issue.
- Acceptance (IDLE, cycle T):
  - If load^store, xfer_size is 1/2/4 and the request is legal: latch addr, size, wr_data and direction.
  - Otherwise (load&store both high, or illegal size): err=1 at T+1, no access, stay IDLE.
- Inputs need only be valid in cycle T.
- Lane math: off = addr[1:0]; mask = (1<<size)-1 over 4 bits; m8 = mask<<off (8 bits).
  - Beat0: word w = addr[ADDR_W+1:2], be = m8[3:0], wdata = wr_data<<(8*off).
  - A request crosses when off+size > 4. Beat1: word w+1, wrapping modulo 2^ADDR_W; be = m8[7:4]; wdata = wr_data>>(8*(4-off)).
- Store, no cross: ISSUE0 at T+1 (mem_en=1, mem_we=1), then IDLE at T+2.
- Store, cross: ISSUE0 at T+1, ISSUE1 at T+2, then IDLE.
- Load, no cross:
  - ISSUE0 at T+1.
  - CAPT at T+2, where mem_rdata is captured.
  - IDLE at T+3 with rd_valid=1.
- Load, cross:
  - ISSUE0 at T+1.
  - ISSUE1 at T+2, capturing beat0 data.
  - CAPT at T+3, capturing beat1 data.
  - rd_valid at T+4.
- rd_data = ({beat1,beat0} >> 8*off) masked to size bytes. rd_data holds until the next rd_valid.
- A new request may be accepted in the same cycle rd_valid is high.
- Reset mid-operation: abort next edge. An already-written store beat0 is not undone; no rd_valid or err is issued.

Optional Feature:
MEM_SPLIT_EN
- Defined: crossing requests execute as two beats as above.
- Undefined: crossing requests are rejected. err=1 at T+1, no mem_en, state stays IDLE, busy stays 0. ISSUE1 logic is not built.

Test Plan:
1. SW, addr 0x10, wr_data 0xDEADBEEF -> at T+1: mem_en=1, we=1, mem_addr=4, be=1111, wdata=0xDEADBEEF; busy high one cycle.
2. SB, addr 0x13, wr_data 0x000000A5 -> mem_addr=4, be=1000, wdata=0xA5000000.
3. LH, addr 0x22, word8=0x12345678 -> be=1100 at T+1; rd_valid at T+3 with rd_data=0x00001234.
4. LW, addr 0x0E, word3=0xAABBCCDD, word4=0x11223344 (MEM_SPLIT_EN) -> beats {addr3, be1100} and {addr4, be0011}; rd_data=0x3344AABB at T+4.
5. SH, addr 0x0F, wr_data 0xBEEF -> with macro: beat0 {3, 1000, 0xEF000000}, beat1 {4, 0001, 0x000000BE}; without macro: err=1 at T+1 and no mem_en.
6. Split load with reset asserted during ISSUE1 -> next cycle IDLE, mem_en=0, no rd_valid. Separately, load=store=1 -> err=1 at T+1 with no access.
